tug_war_referee: RTL and testbench

Game controller for two-player tug-of-war. Consumes single-cycle press pulses from the two per-key player edge-detector blocks and arbitrates simultaneous presses. Moves the one-hot playfield light, detects round wins, keeps per-player score and sequences rounds up to match end. Sits between the player blocks and the LED / 7-segment display drivers.

---
 rtl/tug_war_referee.sv | 175 +++++++++++++++++
 tb/tb_tug_war_referee.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tug_war_referee.sv
// Tug-of-war referee: arbitrates the two press pulses, moves the playfield light,
// scores rounds and sequences the match. Optional per-player lockout: TUG_LOCKOUT_EN.
module tug_war_referee #(
  parameter int N_LEDS         = 9,
  parameter int WIN_SCORE      = 7,
  parameter int HOLD_CYCLES    = 8,
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic              CLOCK,
  input  logic              Reset,
  input  logic              press_l,
  input  logic              press_r,
  output logic [N_LEDS-1:0] led,
  output logic [3:0]        score_l,
  output logic [3:0]        score_r,
  output logic              round_win_l,
  output logic              round_win_r,
  output logic              match_over,
  output logic              match_winner
);

  localparam int PW = $clog2(N_LEDS);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int C  = (N_LEDS - 1) / 2;

  localparam logic [PW-1:0]     POS_C      = PW'(C);
  localparam logic [PW-1:0]     POS_MAX    = PW'(N_LEDS - 1);
  localparam logic [PW-1:0]     POS_ONE    = PW'(1);
  localparam logic [HW-1:0]     HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]     HOLD_ONE   = HW'(1);
  localparam logic [3:0]        WIN_V      = 4'(WIN_SCORE);
  localparam logic [N_LEDS-1:0] LED_ONE    = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] CENTER_LED = LED_ONE << C;
  localparam logic [N_LEDS-1:0] RIGHT_HALF = CENTER_LED - LED_ONE;
  localparam logic [N_LEDS-1:0] LEFT_HALF  = ~(RIGHT_HALF | CENTER_LED);

  typedef enum logic [1:0] {
    ST_PLAY       = 2'd0,
    ST_ROUND_WIN  = 2'd1,
    ST_MATCH_OVER = 2'd2
  } state_e;

  state_e              state_q;
  logic [PW-1:0]       pos_q;
  logic [N_LEDS-1:0]   led_q;
  logic [3:0]          score_l_q, score_r_q;
  logic                round_win_l_q, round_win_r_q;
  logic                match_over_q, match_winner_q;
  logic [HW-1:0]       hold_q;

  logic pl, pr, eff_l, eff_r, win_l, win_r, in_play;
  logic [3:0] score_l_d, score_r_d;

`ifdef TUG_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);
  logic [LW-1:0] lock_l_q, lock_r_q;

  // A locked player's press is dropped before arbitration, so it cannot cancel the opponent.
  assign pl = press_l & (lock_l_q == '0);
  assign pr = press_r & (lock_r_q == '0);

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      lock_l_q <= '0;
      lock_r_q <= '0;
    end else if (in_play && (win_l || win_r)) begin
      lock_l_q <= '0;
      lock_r_q <= '0;
    end else begin
      if (in_play && eff_l)       lock_l_q <= LOCK_LOAD;
      else if (lock_l_q != '0)    lock_l_q <= lock_l_q - LOCK_ONE;
      if (in_play && eff_r)       lock_r_q <= LOCK_LOAD;
      else if (lock_r_q != '0)    lock_r_q <= lock_r_q - LOCK_ONE;
    end
  end
`else
  assign pl = press_l;
  assign pr = press_r;
`endif

  assign eff_l     = pl & ~pr;
  assign eff_r     = pr & ~pl;
  assign in_play   = (state_q == ST_PLAY);
  assign win_l     = eff_l && (pos_q == POS_MAX);
  assign win_r     = eff_r && (pos_q == '0);
  assign score_l_d = score_l_q + 4'd1;
  assign score_r_d = score_r_q + 4'd1;

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_PLAY;
      pos_q          <= POS_C;
      led_q          <= CENTER_LED;
      score_l_q      <= '0;
      score_r_q      <= '0;
      round_win_l_q  <= 1'b0;
      round_win_r_q  <= 1'b0;
      match_over_q   <= 1'b0;
      match_winner_q <= 1'b0;
      hold_q         <= '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (win_l) begin
            score_l_q <= score_l_d;
            if (score_l_d == WIN_V) begin
              state_q        <= ST_MATCH_OVER;
              match_over_q   <= 1'b1;
              match_winner_q <= 1'b0;
              led_q          <= LEFT_HALF;
            end else begin
              state_q       <= ST_ROUND_WIN;
              round_win_l_q <= 1'b1;
              led_q         <= '0;
              hold_q        <= HOLD_LOAD;
            end
          end else if (win_r) begin
            score_r_q <= score_r_d;
            if (score_r_d == WIN_V) begin
              state_q        <= ST_MATCH_OVER;
              match_over_q   <= 1'b1;
              match_winner_q <= 1'b1;
              led_q          <= RIGHT_HALF;
            end else begin
              state_q       <= ST_ROUND_WIN;
              round_win_r_q <= 1'b1;
              led_q         <= '0;
              hold_q        <= HOLD_LOAD;
            end
          end else if (eff_l) begin
            pos_q <= pos_q + POS_ONE;
            led_q <= LED_ONE << (pos_q + POS_ONE);
          end else if (eff_r) begin
            pos_q <= pos_q - POS_ONE;
            led_q <= LED_ONE << (pos_q - POS_ONE);
          end
        end
        ST_ROUND_WIN: begin
          // Counter was loaded with HOLD_CYCLES-1, so this state lasts HOLD_CYCLES cycles.
          if (hold_q == '0) begin
            state_q       <= ST_PLAY;
            pos_q         <= POS_C;
            led_q         <= CENTER_LED;
            round_win_l_q <= 1'b0;
            round_win_r_q <= 1'b0;
          end else begin
            hold_q <= hold_q - HOLD_ONE;
          end
        end
        ST_MATCH_OVER: begin
          state_q <= ST_MATCH_OVER;
        end
        default: begin
          state_q       <= ST_PLAY;
          pos_q         <= POS_C;
          led_q         <= CENTER_LED;
          round_win_l_q <= 1'b0;
          round_win_r_q <= 1'b0;
          match_over_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led          = led_q;
  assign score_l      = score_l_q;
  assign score_r      = score_r_q;
  assign round_win_l  = round_win_l_q;
  assign round_win_r  = round_win_r_q;
  assign match_over   = match_over_q;
  assign match_winner = match_winner_q;

endmodule

// File: tb/tb_tug_war_referee.sv
// Directed bench for tug_war_referee with N_LEDS=9, WIN_SCORE=3, HOLD_CYCLES=4.
module tb_tug_war_referee;

  logic       CLOCK = 1'b0;
  logic       Reset = 1'b1;
  logic       press_l = 1'b0;
  logic       press_r = 1'b0;
  logic [8:0] led;
  logic [3:0] score_l, score_r;
  logic       round_win_l, round_win_r, match_over, match_winner;

  int n_cmp = 0;
  int n_err = 0;

  tug_war_referee #(
    .N_LEDS(9), .WIN_SCORE(3), .HOLD_CYCLES(4), .LOCKOUT_CYCLES(4)
  ) dut (
    .CLOCK(CLOCK), .Reset(Reset), .press_l(press_l), .press_r(press_r),
    .led(led), .score_l(score_l), .score_r(score_r),
    .round_win_l(round_win_l), .round_win_r(round_win_r),
    .match_over(match_over), .match_winner(match_winner)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [8:0] e_led, input logic [3:0] e_sl,
                           input logic [3:0] e_sr, input logic e_rwl, input logic e_rwr,
                           input logic e_mo, input logic e_mw);
    check({tag, ".led"}, 32'(led), 32'(e_led));
    check({tag, ".score_l"}, 32'(score_l), 32'(e_sl));
    check({tag, ".score_r"}, 32'(score_r), 32'(e_sr));
    check({tag, ".round_win_l"}, 32'(round_win_l), 32'(e_rwl));
    check({tag, ".round_win_r"}, 32'(round_win_r), 32'(e_rwr));
    check({tag, ".match_over"}, 32'(match_over), 32'(e_mo));
    if (e_mo) check({tag, ".match_winner"}, 32'(match_winner), 32'(e_mw));
  endtask

  // Called at a negedge: presses are sampled at the next posedge, outputs checked at the following negedge.
  task automatic pulse(input logic l, input logic r);
    press_l = l;
    press_r = r;
    @(negedge CLOCK);
    press_l = 1'b0;
    press_r = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(2);
    check_all("reset", 9'b000010000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.match_winner", 32'(match_winner), 32'd0);
    Reset = 1'b0;

    // Asynchronous reset between clock edges
    pulse(1'b1, 1'b0);
    check("async.pre_led", 32'(led), 32'(9'b000100000));
    #2 Reset = 1'b1;
    #1 check("async.led", 32'(led), 32'(9'b000010000));
    @(negedge CLOCK);
    Reset = 1'b0;

    // Left moves three, right moves one
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("move_l3.led", 32'(led), 32'(9'b010000000));
    pulse(1'b0, 1'b1);
    check("move_r1.led", 32'(led), 32'(9'b001000000));
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("recenter.led", 32'(led), 32'(9'b000010000));

    // Simultaneous presses cancel
    pulse(1'b1, 1'b1);
    check_all("simul", 9'b000010000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Left walks to the edge and scores; hold lasts 4 cycles and ignores presses
    repeat (4) pulse(1'b1, 1'b0);
    check("edge_l.led", 32'(led), 32'(9'b100000000));
    pulse(1'b1, 1'b0);
    check_all("win_l.c0", 9'b0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    check_all("win_l.c1", 9'b0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    check_all("win_l.c2", 9'b0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b1);
    check_all("win_l.c3", 9'b0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_all("win_l.done", 9'b000010000, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Right wins rounds 1 and 2
    repeat (4) pulse(1'b0, 1'b1);
    check("edge_r.led", 32'(led), 32'(9'b000000001));
    pulse(1'b0, 1'b1);
    check_all("win_r1", 9'b0, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    check_all("win_r1.done", 9'b000010000, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) pulse(1'b0, 1'b1);
    check_all("win_r2", 9'b0, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);

    // Right wins the match; further presses change nothing
    repeat (5) pulse(1'b0, 1'b1);
    check_all("match", 9'b000001111, 4'd1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    idle(6);
    check_all("match.sticky", 9'b000001111, 4'd1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);

    do_reset();
    check_all("post_match_reset", 9'b000010000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef TUG_LOCKOUT_EN
    // Second left press within the lockout window is dropped
    pulse(1'b1, 1'b0);
    idle(1);
    pulse(1'b1, 1'b0);
    check("lock.single_move", 32'(led), 32'(9'b000100000));
    do_reset();
    // Locked left press does not cancel the right press
    pulse(1'b1, 1'b0);
    idle(1);
    pulse(1'b1, 1'b1);
    check("lock.no_cancel", 32'(led), 32'(9'b000010000));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
